bus_arb_reg: RTL and testbench
==============================

# bus_arb_reg

Parametrised, registered common-bus unit for the Mano-style datapath. It accepts transfer requests from up to NSRC sources and picks one per cycle, using either fixed-priority or round-robin arbitration. The selected word is captured into a bus register, and a valid/ready handshake holds it until the destination accepts it. It sits between the register file/memory outputs and all bus destinations, and replaces the unclocked source multiplexer.

## Interface
Parameters:
- DATA_W, 16, bus word width; narrower sources (AR, PC) are zero-extended by the instantiator.
- NSRC, 8, number of request/data channels; must be ≥2.
- SEL_W, $clog2(NSRC), width of source index.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- src_data  in  NSRC*DATA_W  flattened source words; channel i at bits [i*DATA_W +: DATA_W].
- req  in  NSRC  per-source request; level, held until granted.
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- lock  in  1  keep the last owner as winner while its req stays high.
- bus_ready  in  1  destination accepts current bus word.
- grant  out  NSRC  one-hot, combinational; high only in the capture cycle.
- bus_out  out  DATA_W  registered bus word.
- bus_valid  out  1  bus_out holds an unconsumed word.
- bus_src  out  SEL_W  index of the source that produced bus_out.

## Operation
- Define `free = !bus_valid || bus_ready`.
- Capture when `free && |req`.
  - bus_out <= winner's word.
  - bus_src <= winner.
  - bus_valid <= 1.
  - grant[winner] = 1 in that same cycle.
- When `free && !|req`: bus_valid <= 0. bus_out and bus_src hold their values.
- When `bus_valid && !bus_ready`: all outputs hold, grant = 0, arbitration pointer frozen.
- Winner selection, in priority order:
  1. lock=1 and req[owner]=1 → owner. owner is the last captured bus_src, and is valid only after the first capture since reset.
  2. mode=0 → lowest set index of req.
  3. mode=1 → first set req at or after pointer rr_ptr, wrapping NSRC-1 → 0.
- rr_ptr update: on each capture, rr_ptr <= (winner+1) mod NSRC, in both modes. It wraps to 0 when winner = NSRC-1.
- Mode switching: mode may change on any cycle and takes effect at the next capture decision. No state is flushed.
- Simultaneous ready and new request: back-to-back capture. The bus sustains one word per cycle with no bubble.
- Sources must drop req the cycle after grant, or a second transfer is taken.
- Reset values (async, rst_n low):
  - bus_out = 0, bus_valid = 0, bus_src = 0.
  - rr_ptr = 0, owner-valid = 0.
  - grant = 0 while rst_n is low.
- Reset asserted mid-transfer discards the held word. No grant is issued while rst_n is low.

## Timing
- Latency is 1 cycle, from req sampled high with free=1 to bus_valid/bus_out on the next edge.
- grant is combinational from req, mode, lock, rr_ptr, bus_valid and bus_ready. It has no registered delay.
- The word is accepted on the edge where bus_valid && bus_ready.
- Throughput is 1 word/cycle while bus_ready stays high.
- Reset release: the first capture is possible on the first rising edge after rst_n deasserts.
- Decision path: no combinational path from bus_ready to bus_out; only grant depends on bus_ready.

## Structure
- Shared package bus_pkg holds:
  - Mode constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - Default widths DATA_W = 16 and NSRC = 8.
  - The Mano source index constants: AR = 0, PC = 1, DR = 2, AC = 3, IR = 4, MEM = 5, TR = 6; index 7 is reserved.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, ptr, mode.
  - Outputs: one-hot gnt and encoded idx.
  - Purely combinational; reused by the memory-port arbiter.
- Top level holds the bus register, the valid flag, rr_ptr, owner, and the lock override.

## Test plan
- Reset: rst_n=0 mid-transfer with bus_valid=1 → bus_valid=0, bus_out=0, bus_src=0 immediately, before any clock edge.
- Fixed priority: mode=0, req=8'b0010_1000, src3=16'h1234, src5=16'hBEEF, bus_ready=1 → grant=8'b0000_1000; next cycle bus_out=16'h1234, bus_src=3.
- Round-robin wrap: mode=1, all req high for 9 cycles, bus_ready=1 → bus_src sequence 0,1,2,…,7,0 with one word every cycle.
- Backpressure: bus_ready=0 with bus_valid=1 and new req on src2 → grant=0 and bus_out unchanged for 4 cycles. The cycle bus_ready rises, grant[2]=1; src2's word appears on the next edge.
- Lock: mode=1, owner=4, lock=1, req=8'b1111_1111 → src4 wins 3 consecutive captures. After lock=0, the next winner is src5.
- Drain: single req on src6, bus_ready=1, then req=0 → bus_valid high for exactly 1 cycle, then 0; bus_out stays at src6's word.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants for the common-bus unit: arbitration modes, default widths
// and the Mano register/memory source indices.
package bus_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int BUS_DATA_W = 16;
  localparam int BUS_NSRC   = 8;

  // Index 7 is reserved.
  localparam int AR  = 0;
  localparam int PC  = 1;
  localparam int DR  = 2;
  localparam int AC  = 3;
  localparam int IR  = 4;
  localparam int MEM = 5;
  localparam int TR  = 6;

endpackage

// File: rtl/bus_arb_reg_if.sv
// Source-side request/data bundle and destination-side bus signals of the
// registered common bus.
interface bus_arb_reg_if #(
  parameter int DATA_W = 16,
  parameter int NSRC   = 8,
  parameter int SEL_W  = $clog2(NSRC)
);

  logic [NSRC*DATA_W-1:0] src_data;
  logic [NSRC-1:0]        req;
  logic                   mode;
  logic                   lock;
  logic                   bus_ready;
  logic [NSRC-1:0]        grant;
  logic [DATA_W-1:0]      bus_out;
  logic                   bus_valid;
  logic [SEL_W-1:0]       bus_src;

  modport slave (
    input  src_data, req, mode, lock, bus_ready,
    output grant, bus_out, bus_valid, bus_src
  );

  modport master (
    output src_data, req, mode, lock, bus_ready,
    input  grant, bus_out, bus_valid, bus_src
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational arbiter: lowest set request in fixed mode, first set request
// at or after ptr (wrapping) in round-robin mode.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int N  = BUS_NSRC,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx
);

  logic          found;
  logic [SW:0]   pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so one conditional subtract is enough to wrap.
      if (mode == MODE_RR) begin
        pos = {1'b0, ptr} + (SW+1)'(k);
        if (pos >= (SW+1)'(N)) pos = pos - (SW+1)'(N);
      end else begin
        pos = (SW+1)'(k);
      end
      if (!found && req[pos[SW-1:0]]) begin
        found = 1'b1;
        idx   = pos[SW-1:0];
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/bus_arb_reg.sv
// Registered common bus: picks one requesting source per cycle, captures its
// word into the bus register and holds it under a valid/ready handshake.
module bus_arb_reg
  import bus_pkg::*;
#(
  parameter int DATA_W = BUS_DATA_W,
  parameter int NSRC   = BUS_NSRC,
  parameter int SEL_W  = $clog2(NSRC)
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_arb_reg_if.slave    bus
);

  logic                free;
  logic                capture;
  logic                use_owner;
  logic                owner_vld;
  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    arb_idx;
  logic [SEL_W-1:0]    win;
  logic [NSRC-1:0]     arb_gnt;
  logic [DATA_W-1:0]   words [NSRC];
  logic [DATA_W-1:0]   bus_out_p1;
  logic [SEL_W-1:0]    bus_src_p1;
  logic                vld_p1;

  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign words[i] = bus.src_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(NSRC), .SW(SEL_W)) u_arb (
    .req  (bus.req),
    .ptr  (rr_ptr),
    .mode (bus.mode),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  // Owner is simply the last captured source; lock overrides the arbiter.
  assign free      = !vld_p1 || bus.bus_ready;
  assign capture   = rst_n && free && (|bus.req);
  assign use_owner = bus.lock && owner_vld && bus.req[bus_src_p1];
  assign win       = use_owner ? bus_src_p1 : arb_idx;

  always_comb begin
    bus.grant = '0;
    if (capture) begin
      if (use_owner) bus.grant[bus_src_p1] = 1'b1;
      else           bus.grant = arb_gnt;
    end
  end

  // Capture stage: bus register, valid flag, owner and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_out_p1 <= '0;
      bus_src_p1 <= '0;
      vld_p1     <= 1'b0;
      owner_vld  <= 1'b0;
      rr_ptr     <= '0;
    end else if (free) begin
      if (|bus.req) begin
        bus_out_p1 <= words[win];
        bus_src_p1 <= win;
        vld_p1     <= 1'b1;
        owner_vld  <= 1'b1;
        rr_ptr     <= (win == SEL_W'(NSRC-1)) ? '0 : win + 1'b1;
      end else begin
        vld_p1     <= 1'b0;
      end
    end
  end

  assign bus.bus_out   = bus_out_p1;
  assign bus.bus_src   = bus_src_p1;
  assign bus.bus_valid = vld_p1;

endmodule

// File: tb/tb_bus_arb_reg.sv
// Directed and random checks of bus_arb_reg against a transaction-level model
// of the arbitration rules.
module tb_bus_arb_reg;

  localparam int DW = 16;
  localparam int NS = 8;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [DW-1:0] words [NS];

  // Reference model state
  bit       m_valid;
  bit [DW-1:0] m_out;
  int       m_src;
  int       m_ptr;
  bit       m_own_vld;
  int       last_win;

  bus_arb_reg_if #(.DATA_W(DW), .NSRC(NS)) bus ();

  bus_arb_reg #(.DATA_W(DW), .NSRC(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [NS-1:0] r, input logic md, input logic lk);
    if (lk && m_own_vld && r[m_src]) return m_src;
    if (md == 1'b0) begin
      for (int i = 0; i < NS; i++) if (r[i]) return i;
    end else begin
      for (int k = 0; k < NS; k++) if (r[(m_ptr + k) % NS]) return (m_ptr + k) % NS;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_out = '0; m_src = 0; m_ptr = 0; m_own_vld = 0;
  endtask

  task automatic drive_data();
    for (int i = 0; i < NS; i++) bus.src_data[i*DW +: DW] = words[i];
  endtask

  // One clock: apply inputs, check grant, clock, update model, check bus outputs.
  task automatic cycle(input logic [NS-1:0] r, input logic md, input logic lk, input logic rdy);
    logic [NS-1:0] exp_g;
    int w;
    bit fr;
    bus.req = r; bus.mode = md; bus.lock = lk; bus.bus_ready = rdy;
    drive_data();
    #1;
    fr = !m_valid || rdy;
    w  = -1;
    exp_g = '0;
    if (fr && r != '0) begin
      w = model_winner(r, md, lk);
      exp_g[w] = 1'b1;
    end
    chk("grant", 32'(bus.grant), 32'(exp_g));
    @(posedge clk);
    if (fr) begin
      if (w >= 0) begin
        m_out = words[w]; m_src = w; m_valid = 1; m_own_vld = 1;
        m_ptr = (w + 1) % NS;
      end else begin
        m_valid = 0;
      end
    end
    last_win = w;
    #1;
    chk("bus_valid", 32'(bus.bus_valid), 32'(m_valid));
    chk("bus_out",   32'(bus.bus_out),   32'(m_out));
    chk("bus_src",   32'(bus.bus_src),   32'(m_src));
  endtask

  // Asynchronous reset assertion away from the clock edge, checked before any edge.
  task automatic do_reset();
    bus.req = '1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.bus_valid), 32'd0);
    chk("rst_out",   32'(bus.bus_out),   32'd0);
    chk("rst_src",   32'(bus.bus_src),   32'd0);
    chk("rst_grant", 32'(bus.grant),     32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_grant_edge", 32'(bus.grant), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] held;
    rst_n = 1'b0;
    bus.req = '0; bus.mode = 1'b0; bus.lock = 1'b0; bus.bus_ready = 1'b0;
    for (int i = 0; i < NS; i++) words[i] = DW'($urandom);
    drive_data();
    model_reset();
    #2;
    do_reset();

    // Fixed priority
    words[3] = 16'h1234; words[5] = 16'hBEEF;
    cycle(8'b0010_1000, 1'b0, 1'b0, 1'b1);
    chk("fp_out", 32'(bus.bus_out), 32'h1234);
    chk("fp_src", 32'(bus.bus_src), 32'd3);

    // Round-robin wrap from a fresh pointer
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(8'hFF, 1'b1, 1'b0, 1'b1);
      chk("rr_src", 32'(bus.bus_src), 32'(i % NS));
      chk("rr_valid", 32'(bus.bus_valid), 32'd1);
    end

    // Backpressure with a pending request on src2
    held = bus.bus_out;
    for (int i = 0; i < 4; i++) begin
      words[0] = DW'($urandom);
      cycle(8'b0000_0100, 1'b1, 1'b0, 1'b0);
      chk("bp_hold", 32'(bus.bus_out), 32'(held));
    end
    words[2] = 16'hC0DE;
    cycle(8'b0000_0100, 1'b1, 1'b0, 1'b1);
    chk("bp_src", 32'(bus.bus_src), 32'd2);
    chk("bp_out", 32'(bus.bus_out), 32'hC0DE);

    // Lock: establish owner 4, then hold it against all requesters
    cycle(8'b0001_0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(8'hFF, 1'b1, 1'b1, 1'b1);
      chk("lock_src", 32'(bus.bus_src), 32'd4);
    end
    cycle(8'hFF, 1'b1, 1'b0, 1'b1);
    chk("unlock_src", 32'(bus.bus_src), 32'd5);

    // Drain: single word from src6, then idle
    words[6] = 16'h6666;
    cycle(8'b0100_0000, 1'b0, 1'b0, 1'b1);
    chk("drain_v1", 32'(bus.bus_valid), 32'd1);
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    chk("drain_v0", 32'(bus.bus_valid), 32'd0);
    chk("drain_out", 32'(bus.bus_out), 32'h6666);

    // Reset while a word is held under backpressure
    cycle(8'b0000_0010, 1'b0, 1'b0, 1'b0);
    cycle(8'b0000_0010, 1'b0, 1'b0, 1'b0);
    chk("mid_valid_pre", 32'(bus.bus_valid), 32'd1);
    do_reset();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++) words[i] = DW'($urandom);
      cycle(NS'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
